// File: rtl/tiniest_gpu_pkg.sv
// Shared constants, FSM state type and colour bit map for the tiniest_gpu tile.
// Sync outputs are controlled by TINIEST_GPU_SYNC_OUT_EN (see tiniest_gpu.sv).
package tiniest_gpu_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned UART_DIV    = 27;
    localparam int unsigned OVERSAMPLE  = 16;
    localparam int unsigned CFG_BYTES   = 60;
    localparam int unsigned PREP_CYCLES = 56000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RX_CFG,
        ST_PREP,
        ST_DISPLAY
    } state_t;

    localparam int unsigned R1_BIT   = 0;
    localparam int unsigned R0_BIT   = 4;
    localparam int unsigned G1_BIT   = 2;
    localparam int unsigned G0_BIT   = 6;
    localparam int unsigned B1_BIT   = 1;
    localparam int unsigned B0_BIT   = 5;
    localparam int unsigned BUSY_BIT = 3;

    // rgb is the texel layout {R[1:0], G[1:0], B[1:0]}
    function automatic logic [7:0] pack_colour(input logic [5:0] rgb, input logic busy);
        logic [7:0] o;
        o           = '0;
        o[R1_BIT]   = rgb[5];
        o[R0_BIT]   = rgb[4];
        o[G1_BIT]   = rgb[3];
        o[G0_BIT]   = rgb[2];
        o[B1_BIT]   = rgb[1];
        o[B0_BIT]   = rgb[0];
        o[BUSY_BIT] = busy;
        return o;
    endfunction

endpackage

// File: rtl/tiniest_gpu_uart_rx.sv
// UART byte receiver: free-running oversample tick, falling-edge start, 16 ticks/bit.
// Bits are sampled at tick 16*k after the start edge; a low stop bit drops the byte.
module tiniest_gpu_uart_rx #(
    parameter int unsigned UART_DIV = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       start_edge,
    output logic [7:0] data,
    output logic       valid
);
    import tiniest_gpu_pkg::*;

    localparam int unsigned STOP_TICK = OVERSAMPLE * 9;

    logic [15:0] div_cnt;
    logic        tick;
    logic        rx_s1, rx_s2;
    logic        active;
    logic [7:0]  tcnt, tcnt_nxt;
    logic [7:0]  shreg;

    assign tick       = (div_cnt == 16'(UART_DIV - 1));
    assign start_edge = !active && rx_s2 && !rx_s1;
    assign tcnt_nxt   = tcnt + 8'd1;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            div_cnt <= '0;
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            active  <= 1'b0;
            tcnt    <= '0;
            shreg   <= '0;
            data    <= '0;
            valid   <= 1'b0;
        end else begin
            valid   <= 1'b0;
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            div_cnt <= tick ? '0 : div_cnt + 16'd1;
            if (start_edge) begin
                active <= 1'b1;
                tcnt   <= '0;
            end else if (active && tick) begin
                tcnt <= tcnt_nxt;
                if (tcnt_nxt[3:0] == 4'd0) begin
                    if (tcnt_nxt == 8'(STOP_TICK)) begin
                        active <= 1'b0;
                        if (rx_s1) begin
                            data  <= shreg;
                            valid <= 1'b1;
                        end
                    end else begin
                        shreg <= {rx_s1, shreg[7:1]};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tiniest_gpu.sv
// Textured VGA tile: scan-chain texture load, UART frame config, 640x480 scan-out.
// Define TINIEST_GPU_SYNC_OUT_EN to drive hsync/vsync on uo_out[1:0].
module tiniest_gpu #(
    parameter int unsigned UART_DIV    = tiniest_gpu_pkg::UART_DIV,
    parameter int unsigned CFG_BYTES   = tiniest_gpu_pkg::CFG_BYTES,
    parameter int unsigned PREP_CYCLES = tiniest_gpu_pkg::PREP_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uo_out,
    inout  wire        VDD,
    inout  wire        VSS
);
    import tiniest_gpu_pkg::*;

    localparam int unsigned PREP_W = $clog2(PREP_CYCLES + 1);

    state_t              state, state_nxt;
    logic                start_edge, byte_valid;
    logic [7:0]          byte_data;
    logic [19:0]         master, sr;
    logic [7:0]          mem [0:2047];
    logic [7:0]          rdata;
    logic [10:0]         raddr;
    logic [7:0]          u_off, v_off, byte_cnt;
    logic                tex_en;
    logic [5:0]          solid, pix;
    logic [PREP_W-1:0]   prep_cnt;
    logic [9:0]          x, y, x_nxt, y_nxt;
    logic                ph, ph_nxt;
    logic [5:0]          u;
    logic [4:0]          v;
    logic                visible;
    logic                unused;

    tiniest_gpu_uart_rx #(.UART_DIV(UART_DIV)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (ui_in[3]),
        .start_edge (start_edge),
        .data       (byte_data),
        .valid      (byte_valid)
    );

    // Two-phase chain emulated on clk: repeated phi1/phi2 samples are idempotent.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            master <= '0;
            sr     <= '0;
        end else begin
            if (uio_in[0]) master <= {sr[18:0], uio_in[4]};
            if (uio_in[1]) sr     <= master;
        end
    end

    always_ff @(posedge clk) begin
        if (uio_in[3]) mem[sr[18:8]] <= sr[7:0];
    end

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (start_edge) state_nxt = ST_RX_CFG;
            ST_RX_CFG:  if (byte_valid && byte_cnt == 8'(CFG_BYTES - 1)) state_nxt = ST_PREP;
            ST_PREP:    if (prep_cnt == PREP_W'(PREP_CYCLES - 1)) state_nxt = ST_DISPLAY;
            ST_DISPLAY: if (start_edge) state_nxt = ST_RX_CFG;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Coordinates valid after the next edge; the texel read targets them.
    always_comb begin
        ph_nxt = 1'b0;
        x_nxt  = '0;
        y_nxt  = '0;
        if (state == ST_DISPLAY && state_nxt == ST_DISPLAY) begin
            ph_nxt = ~ph;
            x_nxt  = x;
            y_nxt  = y;
            if (ph) begin
                if (x == 10'(H_TOTAL - 1)) begin
                    x_nxt = '0;
                    y_nxt = (y == 10'(V_TOTAL - 1)) ? '0 : y + 10'd1;
                end else begin
                    x_nxt = x + 10'd1;
                end
            end
        end
    end

    assign u     = x_nxt[8:3] + u_off[5:0];
    assign v     = y_nxt[7:3] + v_off[4:0];
    assign raddr = {v, u};

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= ST_IDLE;
            x        <= '0;
            y        <= '0;
            ph       <= 1'b0;
            prep_cnt <= '0;
            byte_cnt <= '0;
            u_off    <= '0;
            v_off    <= '0;
            tex_en   <= 1'b0;
            solid    <= '0;
        end else begin
            state    <= state_nxt;
            x        <= x_nxt;
            y        <= y_nxt;
            ph       <= ph_nxt;
            prep_cnt <= (state == ST_PREP) ? prep_cnt + PREP_W'(1) : '0;
            if (state != ST_RX_CFG) begin
                byte_cnt <= '0;
            end else if (byte_valid) begin
                byte_cnt <= byte_cnt + 8'd1;
                case (byte_cnt)
                    8'd0:    u_off  <= byte_data;
                    8'd1:    v_off  <= byte_data;
                    8'd2:    tex_en <= byte_data[0];
                    8'd3:    solid  <= byte_data[5:0];
                    default: ;
                endcase
            end
        end
    end

    assign visible = (state == ST_DISPLAY) && (x < 10'(H_VISIBLE)) && (y < 10'(V_VISIBLE));

    always_comb begin
        pix = '0;
        if (visible) pix = tex_en ? rdata[5:0] : solid;
    end

    assign uio_out = pack_colour(pix, state == ST_RX_CFG);

`ifdef TINIEST_GPU_SYNC_OUT_EN
    logic hsync, vsync;
    assign hsync  = !((x >= 10'(H_VISIBLE + H_FRONT)) && (x < 10'(H_VISIBLE + H_FRONT + H_SYNC)));
    assign vsync  = !((y >= 10'(V_VISIBLE + V_FRONT)) && (y < 10'(V_VISIBLE + V_FRONT + V_SYNC)));
    assign uo_out = (state == ST_DISPLAY) ? {6'b0, vsync, hsync} : '0;
`else
    assign uo_out = '0;
`endif

    assign unused = ^{ena, ui_in, uio_in, rdata[7:6], u_off, v_off, byte_data, sr[19],
                      x_nxt, y_nxt, VDD, VSS};

endmodule

// File: tb/tb_tiniest_gpu.sv
// Directed bench for tiniest_gpu: texture load, UART config bursts, pixel and timing checks.
// Runs with a shortened UART divider and prep time; VGA timing is unchanged.
module tb_tiniest_gpu;

    localparam int unsigned DIV  = 1;
    localparam int unsigned PREP = 200;
    localparam logic [7:0]  TEXEL_OUT = 8'h65;  // texel 0x2D on the uio_out bit map
    localparam logic [7:0]  WHITE_OUT = 8'h77;  // R=G=B=3

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ena = 1'b1;
    logic [7:0]  ui_in = 8'h08;
    logic [7:0]  uio_in = 8'h00;
    logic [7:0]  uio_out, uo_out;
    wire         vdd = 1'b1;
    wire         vss = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned ce = 0;
    int unsigned fall_cyc = 0;
    bit          fall_seen = 1'b0;
    bit          busy_prev = 1'b0;

    tiniest_gpu #(.UART_DIV(DIV), .CFG_BYTES(60), .PREP_CYCLES(PREP)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uo_out  (uo_out),
        .VDD     (vdd),
        .VSS     (vss)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy_prev && !uio_out[3] && !fall_seen) begin
            fall_cyc  = cyc;
            fall_seen = 1'b1;
        end
        busy_prev = uio_out[3];
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_write(input logic [10:0] addr, input logic [7:0] data);
        logic [19:0] w;
        w = {1'b0, addr, data};
        for (int i = 19; i >= 0; i--) begin
            uio_in[4] = w[i];
            @(negedge clk) uio_in[0] = 1'b1;
            @(negedge clk) uio_in[0] = 1'b0;
            @(negedge clk) uio_in[1] = 1'b1;
            @(negedge clk) uio_in[1] = 1'b0;
        end
        @(negedge clk) uio_in[3] = 1'b1;
        @(negedge clk) uio_in[3] = 1'b0;
    endtask

    // Half-length start bit puts every 16-tick sample mid-bit for this receiver.
    task automatic send_byte(input logic [7:0] d, input logic stop, input bit first);
        @(negedge clk) ui_in[3] = 1'b0;
        if (first) begin
            wait_neg(1);
            check("busy_pre", uio_out[3], 1'b0);
            wait_neg(1);
            check("busy_rise", uio_out[3], 1'b1);
            wait_neg(8 * DIV - 2);
        end else begin
            wait_neg(8 * DIV);
        end
        for (int i = 0; i < 8; i++) begin
            ui_in[3] = d[i];
            wait_neg(16 * DIV);
        end
        ui_in[3] = stop;
        wait_neg(16 * DIV);
        ui_in[3] = 1'b1;
        wait_neg(8 * DIV);
    endtask

    task automatic send_cfg(input logic [7:0] uo, input logic [7:0] vo, input logic [7:0] en,
                            input logic [7:0] sc, input int bad_at);
        logic [7:0] b;
        fall_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i == bad_at) send_byte(8'h00, 1'b0, 1'b0);
            case (i)
                0:       b = uo;
                1:       b = vo;
                2:       b = en;
                3:       b = sc;
                default: b = 8'(i * 7);
            endcase
            send_byte(b, 1'b1, i == 0);
            if (i == 58) check("busy_hold", uio_out[3], 1'b1);
        end
        for (int i = 0; i < 1000 && !fall_seen; i++) @(negedge clk);
        check("busy_fall", fall_seen, 1'b1);
        ce = fall_cyc;
    endtask

    task automatic pixel_at(input string tag, input int unsigned px, input int unsigned py,
                            input int half, input logic [7:0] exp);
        int unsigned target;
        target = ce + PREP + 2 * (py * 800 + px) + half;
        while (cyc < target) @(negedge clk);
        check(tag, uio_out, exp);
    endtask

    initial begin
        logic [10:0] a;
        logic [7:0]  sync_act, sync_idle;
`ifdef TINIEST_GPU_SYNC_OUT_EN
        sync_act  = 8'h02;
        sync_idle = 8'h03;
`else
        sync_act  = 8'h00;
        sync_idle = 8'h00;
`endif
        wait_neg(5);
        check("rst_uio", uio_out, 8'h00);
        check("rst_uo", uo_out, 8'h00);
        rst_n = 1'b0;
        wait_neg(5);
        check("idle_uio", uio_out, 8'h00);

        for (int i = 0; i < 32; i++) begin
            a = (i < 16) ? 11'(i) : 11'(32'h40 + i - 16);
            scan_write(a, (a == 11'h005) ? 8'h2D : (a == 11'h006) ? 8'hC0 : 8'h00);
        end

        // Config 1: U=V=0, texture on, a dropped byte ahead of the enable byte
        send_cfg(8'd0, 8'd0, 8'h01, 8'h00, 2);
        pixel_at("t1_x39y0", 39, 0, 0, 8'h00);
        pixel_at("t1_x40y0", 40, 0, 0, TEXEL_OUT);
        pixel_at("t1_x40y0_hold", 40, 0, 1, TEXEL_OUT);
        pixel_at("t1_x48y0_hi_bits", 48, 0, 0, 8'h00);
        pixel_at("t1_x552_wrap", 552, 0, 0, TEXEL_OUT);
        pixel_at("t1_blank", 640, 0, 0, 8'h00);
        pixel_at("t1_sync_idle", 640, 0, 1, 8'h00);
        check("t1_uo_idle", uo_out, sync_idle);
        pixel_at("t1_hsync", 700, 0, 0, 8'h00);
        check("t1_uo_hsync", uo_out, sync_act);
        pixel_at("t1_x47y7", 47, 7, 0, TEXEL_OUT);
        pixel_at("t1_x40y8", 40, 8, 0, 8'h00);

        // Config 2 aborts the running frame: U=1 shifts the texel left by 8 pixels
        send_cfg(8'd1, 8'd0, 8'h01, 8'h00, 99);
        pixel_at("t2_x31", 31, 0, 0, 8'h00);
        pixel_at("t2_x32", 32, 0, 0, TEXEL_OUT);
        pixel_at("t2_x39", 39, 0, 0, TEXEL_OUT);
        pixel_at("t2_x40", 40, 0, 0, 8'h00);

        // Config 3: solid colour, exact first-pixel latency
        send_cfg(8'd0, 8'd0, 8'h00, 8'hFF, 99);
        pixel_at("t3_prep_last", 0, 0, -1, 8'h00);
        pixel_at("t3_first_px", 0, 0, 0, WHITE_OUT);
        pixel_at("t3_x639", 639, 0, 0, WHITE_OUT);
        pixel_at("t3_x640", 640, 0, 0, 8'h00);
        pixel_at("t3_x799", 799, 0, 1, 8'h00);
        pixel_at("t3_x0y1", 0, 1, 0, WHITE_OUT);

        // Mid-frame reset, then texture must survive
        rst_n = 1'b1;
        wait_neg(2);
        check("mid_rst_uio", uio_out, 8'h00);
        check("mid_rst_uo", uo_out, 8'h00);
        rst_n = 1'b0;
        wait_neg(20);
        check("post_rst_idle", uio_out, 8'h00);
        send_cfg(8'd0, 8'd0, 8'h01, 8'h00, 99);
        pixel_at("t4_x40", 40, 0, 0, TEXEL_OUT);
        pixel_at("t4_x48", 48, 0, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tiniest_gpu.md
# tiniest_gpu

Top-level tile of a minimal textured-display GPU. Holds a 2048-byte texture memory loaded through a two-phase scan chain, receives a 60-byte frame configuration over UART, then scans out a 640x480 VGA frame. Each visible pixel is a texel lookup producing 2-bit R/G/B on uio_out.

## Interface
- UART_DIV, 27: clk cycles per UART sample tick; 16 ticks per bit, so 115.2 kbaud at 50 MHz.
- CFG_BYTES, 60: bytes per configuration burst.
- PREP_CYCLES, 56000: clk cycles from configuration done to pixel (0,0).
- clk  in  1  system clock, 50 MHz. Reset rst_n, asynchronous, active-high; clock clk.
- rst_n  in  1  reset.
- ena  in  1  tile enable; ignored.
- ui_in  in  8  bit3 = UART rx, idles high; other bits unused.
- uio_in  in  8  bit0 = phi1, bit1 = phi2, bit4 = scan data, bit3 = texture write strobe; others unused.
- uio_out  out  8  pixel colour and busy flag; bit map under Operation.
- uo_out  out  8  bit0 = hsync, bit1 = vsync (macro-gated); bits 7:2 = 0.
- VDD, VSS  inout  1  supply pins; no logic.

## Operation
- **uio_out bit map:**
  - Red: R[1]→0, R[0]→4.
  - Green: G[1]→2, G[0]→6.
  - Blue: B[1]→1, B[0]→5.
  - Bit 3 = busy. Bit 7 = 0.
- **Scan chain:** 20-bit shift register. Master stage captures uio_in[4] while phi1 is high; slave stage updates while phi2 is high (phi1/phi2 non-overlapping). Shift order, MSB first: 1 pad bit, addr[10:0], data[7:0]. After 20 shifts, addr = sr[18:8] and data = sr[7:0].
- **Texture write:** strobe sampled on clk; when high, mem[addr] <= data. One write per strobe cycle. Texel byte format is [5:4] = R, [3:2] = G, [1:0] = B; bits 7:6 are ignored.
- **UART receiver:**
  - Free-running tick counter issues sample_tick every UART_DIV clk.
  - Start is detected by a falling edge on rx; the low level is not validated.
  - Data bits are sampled LSB first at the 16th, 32nd, … 128th tick after the edge. The stop bit is sampled at the 144th tick.
  - A low stop bit discards the byte. The receiver re-arms after the stop sample.
- **Config store:** bytes 0..59 counted in order. Used fields:
  - Byte 0 = U offset.
  - Byte 1 = V offset.
  - Byte 2 bit0 = texture enable.
  - Byte 3[5:0] = solid colour.
  - Bytes 4..59 are received and discarded.
- **Top FSM:**
  - IDLE: a start edge moves to RX_CFG.
  - RX_CFG: after the 60th byte's stop sample, moves to PREP.
  - PREP: counts PREP_CYCLES, then moves to DISPLAY.
  - DISPLAY: free-running frames. A start edge moves to RX_CFG, aborts the frame and restarts the byte count.
- **Busy flag:** uio_out[3] = 1 in RX_CFG, else 0.
- **VGA timing:** pixel = 2 clk. Horizontal 800 total: 640 visible, 16 front porch, 96 sync, 48 back porch. Vertical 525 total: 480 visible, 10 front porch, 2 sync, 33 back porch. Syncs active-low.
- **Pixel colour:**
  - u = (x>>3) + U mod 64; v = (y>>3) + V mod 32; addr = {v[4:0], u[5:0]}.
  - Output the texel if texture is enabled, else the solid colour.
  - Blanking, IDLE, RX_CFG and PREP output 0.

## Timing
- **Reset:** all outputs 0, FSM IDLE, counters 0. Texture memory is not cleared.
- **Busy rise:** busy rises on the clk after the start edge is detected. It falls on the clk after the 60th stop sample; call that edge E.
- **First pixel:** pixel (0,0) is valid after rising edge E+PREP_CYCLES. Each pixel is held 2 clk. Frame period is 840000 clk.
- **Texture memory:** read is synchronous. Lookup is pipelined so the colour aligns with its pixel; the address is computed one pixel ahead.
- **Write/read collision:** a strobe during DISPLAY writes; the read returns old data for that cycle.

## Configuration
- TINIEST_GPU_SYNC_OUT_EN defined: uo_out[0] = hsync, uo_out[1] = vsync.
- Not defined: uo_out = 0 and the sync logic is removed. Pixel timing is unchanged.

## Structure
- Package tiniest_gpu_pkg holds:
  - VGA constants (visible, porch and sync widths; totals 800/525).
  - UART_DIV, the 16x oversample count, CFG_BYTES, PREP_CYCLES.
  - FSM state enum.
  - Colour bit-map constants.
- Sub-module: tiniest_gpu_uart_rx (tick generator and byte receiver, outputs byte + valid).

## Test plan
- Scan-load addr 0x005 = 0x2D, other texels 0; config U=V=0, texture on → pixels x 40..47, y 0..7 give R=2, G=3, B=1 (uio_out[0]=1, [4]=0, [2]=1, [6]=1, [1]=0, [5]=1); all other pixels give 0.
- Same texture with U=1 → colour moves to x 32..39.
- Texture off, byte3 = 0x3F → all 307200 visible pixels give R=G=B=3; blanking gives 0.
- Send 60 bytes → busy is 1 from the first start until the last stop; pixel (0,0) appears exactly 56000 clk after busy falls.
- Byte with stop bit low → not counted; busy stays high until 60 valid bytes are received.
- Assert rst_n mid-frame → outputs 0, FSM IDLE; texture contents are preserved.
